// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered one-hot grant and binary grant code.
// Owners keep the grant until done or withdrawal, or until the hold limit expires while others wait.
module rr_grant_encoder #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_code,
    output logic             grant_valid
);

    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [HW-1:0]    hold_cnt;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             others;
    logic             release_own;

    // Scan from ptr upward; IDX_W-bit addition wraps the search back to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // grant is one-hot while owning, so masking it out leaves only competing requests.
    assign others      = |(req & ~grant);
    assign release_own = done || !req[grant_code] || ((hold_cnt == HOLD_LAST) && others);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_code  <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (found) begin
                        grant       <= N'(1) << win;
                        grant_code  <= win;
                        grant_valid <= 1'b1;
                        state       <= OWN;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        grant       <= '0;
                        grant_code  <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_code + IDX_W'(1);
                        hold_cnt    <= '0;
                        state       <= IDLE;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: a behavioural owner/pointer model checked every cycle,
// plus literal expectations for each scenario.
module tb_rr_grant_encoder;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int HOLD_MAX = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_code;
    logic             grant_valid;

    int total = 0;
    int bad   = 0;

    rr_grant_encoder #(.N(N), .IDX_W(IDX_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_code(grant_code), .grant_valid(grant_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: current owner (-1 = none), rotation start, cycles the owner has held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    always @(negedge rst_n) begin
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
    end

    always @(posedge clk) begin
        logic [N-1:0] oh;
        logic [N-1:0] e_grant;
        bit           rel;
        int           w;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else begin
            oh  = N'(1) << m_owner;
            rel = done || !req[m_owner] || (m_held >= HOLD_MAX && (req & ~oh) != 0);
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end
        #1;
        e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
        chk("model_grant", 32'(grant), 32'(e_grant));
        chk("model_code", 32'(grant_code), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("model_valid", 32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    end

    task automatic drive(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_g(input string name, input logic [N-1:0] g, input logic [IDX_W-1:0] c);
        chk({name, "_grant"}, 32'(grant), 32'(g));
        chk({name, "_code"}, 32'(grant_code), 32'(c));
        chk({name, "_valid"}, 32'(grant_valid), (g != 0) ? 32'd1 : 32'd0);
    endtask

    logic [N-1:0] alt [5];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        alt[0] = 8'h01; alt[1] = 8'h00; alt[2] = 8'h80; alt[3] = 8'h00; alt[4] = 8'h01;

        tick(); tick();
        expect_g("reset", 8'h00, 3'd0);
        @(negedge clk) rst_n = 1'b1;

        // single requester, then done; ptr=1 shown by picking 1 over 0
        drive(8'h01, 1'b0); tick(); expect_g("t1_grant", 8'h01, 3'd0);
        drive(8'h01, 1'b1); tick(); expect_g("t1_rel", 8'h00, 3'd0);
        drive(8'h03, 1'b0); tick(); expect_g("t1_ptr1", 8'h02, 3'd1);
        drive(8'h00, 1'b1); tick(); expect_g("t1_idle", 8'h00, 3'd0);

        // alternating 0 and 7 with idle gaps
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        drive(8'h81, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_g($sformatf("t2_%0d", i), alt[i], (alt[i] == 8'h80) ? 3'd7 : 3'd0);
        end

        // full rotation with wrap
        @(negedge clk) begin rst_n = 1'b0; req = 8'hFF; done = 1'b1; end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(); expect_g($sformatf("t3_g%0d", i), N'(1) << (i % N), IDX_W'(i % N));
            tick(); expect_g($sformatf("t3_i%0d", i), 8'h00, 3'd0);
        end

        // hold limit forces rotation after four grant cycles
        drive(8'h04, 1'b0); tick(); expect_g("t4_own", 8'h04, 3'd2);
        drive(8'h24, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_g($sformatf("t4_hold%0d", i), 8'h04, 3'd2);
        end
        tick(); expect_g("t4_rel", 8'h00, 3'd0);
        tick(); expect_g("t4_next", 8'h20, 3'd5);

        // owner 3 holds alone indefinitely, then withdraws; ptr=4 picks 4 over 0 and 5
        drive(8'h08, 1'b0); tick(); expect_g("t5_rel5", 8'h00, 3'd0);
        tick(); expect_g("t5_own", 8'h08, 3'd3);
        repeat (6) tick();
        expect_g("t5_alone", 8'h08, 3'd3);
        drive(8'h31, 1'b0); tick(); expect_g("t5_drop", 8'h00, 3'd0);
        tick(); expect_g("t5_ptr4", 8'h10, 3'd4);

        // asynchronous reset mid-ownership; ptr back to 0, then owner 4 regranted
        #1 rst_n = 1'b0;
        #1 expect_g("t6_async", 8'h00, 3'd0);
        @(negedge clk) begin rst_n = 1'b1; req = 8'h11; done = 1'b0; end
        tick(); expect_g("t6_ptr0", 8'h01, 3'd0);
        drive(8'h10, 1'b1); tick(); expect_g("t6_rel", 8'h00, 3'd0);
        tick(); expect_g("t6_regrant", 8'h10, 3'd4);

        drive(8'h00, 1'b1); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
